aximm_aib_top_core: RTL and testbench
=====================================

# aximm_aib_top_core

Single-clock AXI-MM-over-AIB link exerciser with an AVMM control port. It models link bring-up, then runs a 128-beat, 128-bit incremental-pattern AXI write burst across a modelled link into a far-side memory, and a matching read burst that it checks against the expected pattern. Status and captured beats are readable over AVMM. It sits in the AXI-MM system testbench in place of the full leader/follower AIB stack.

## Interface
- `BURST_LEN`, 128: beats per burst, 2..256.
- `LINK_LAT`, 4: one-way modelled link latency in cycles, ≥1.
- `ms_wr_clk` in 1: sole clock; all logic on its rising edge.
- `i_w_m_wr_rst` in 1: reset, synchronous, active-high.
- `i_wren` in 1: AVMM write request, level; commits once per rising edge.
- `i_rden` in 1: AVMM read request, level; one read per rising edge.
- `i_wr_addr` in 32: AVMM byte address, shared by reads and writes.
- `i_wrdata` in 32: AVMM write data.
- `o_master_readdata` out 32: read data.
- `o_master_readdatavalid` out 1: read data valid, held (see Timing).
- `o_master_waitrequest` out 1: tied 0.
- `tx_online` out 1: LINKUP_STS[0].
- `rx_online` out 1: LINKUP_STS[1].
- `test_done` out 1: BUS_STS[1].

## Operation
- Register map, 32-bit, unmapped addresses read 0, writes to read-only registers ignored:
  - 0x5000_1000 WR_CFG: bit2 = write-burst start; other bits stored, readback only.
  - 0x5000_1004 WR_RD_ADDR: seed/base, reset 0.
  - 0x5000_1008 BUS_STS, RO: [0] compare pass; [1] compare done; [2] ms aligned; [3] sl aligned; [4] write complete; [5] read complete.
  - 0x5000_100C LINKUP_STS, RO: [0] tx_online; [1] rx_online; [2] ms aligned; [3] sl aligned.
  - 0x5000_1010 RD_CFG: bit2 = read-burst start.
  - 0x5000_2000/04/08 DELAY_X/Y/Z: reset 12/32/6000.
  - 0x5000_4000–0C DOUT_FIRST, 4000+0x10–1C DOUT_LAST, +0x20 DIN_FIRST, +0x30 DIN_LAST: 128-bit captures; word at offset +0 is bits[31:0]. All RO, reset 0.
- Link bring-up: free counter from reset, saturating.
  - `tx_online` when count ≥ X.
  - `rx_online` when count ≥ X+Y.
  - Aligned bits when count ≥ X+Y+Z.
  - Delay registers are compared live.
- Pattern: word j (0..3) of beat k = seed + 4k + j, mod 2^32. Seed 0x1000_0000 gives beat 0 = 0x10000003_10000002_10000001_10000000.
- Write burst:
  - Started by a WR_CFG commit with bit2=1, while link is aligned and the engine is idle; otherwise the start is ignored.
  - Clears BUS_STS[5,4,1,0].
  - Emits one beat per cycle into a LINK_LAT-deep pipe feeding a BURST_LEN×128 memory. Memory is not reset.
  - Captures DOUT_FIRST/LAST.
- Read burst:
  - RD_CFG bit2, same start conditions; clears BUS_STS[5,1,0].
  - Reads one beat per cycle through a LINK_LAT return pipe.
  - Compares each beat to the expected pattern using the current seed.
  - Captures DIN_FIRST/LAST.
  - After the last beat: [5]=1, [1]=1, [0]=1 only if every beat matched.
- Engine states: IDLE → WR → WR_DRAIN → IDLE; IDLE → RD → RD_DRAIN → IDLE. Write and read bursts never overlap.

## Timing
- AVMM write: register updates on the cycle after `i_wren` is sampled rising.
- AVMM read:
  - `i_rden` sampled rising clears `o_master_readdatavalid` the same cycle.
  - Data and valid are asserted 2 cycles later.
  - Both are held until the next `i_rden` rising edge.
- Write burst: first beat enters the pipe the cycle after start. BUS_STS[4] sets LINK_LAT cycles after the last beat is issued.
- Read burst: BUS_STS[5] sets 2×LINK_LAT cycles after the last address is issued.
- Reset mid-burst: engine returns to IDLE, all status, captures and config are reset, and the bring-up counter restarts.
- Outputs in reset: all 0, except delay registers at their defaults.

## Configuration
- `AXIMM_ERR_INJECT_EN` defined:
  - RD_CFG bit31 becomes writable.
  - When set, bit 0 of read beat 0 is inverted before compare and capture, so BUS_STS[3:0] reads 1110.
- Undefined: bit31 reads 0 and no inversion logic is present.

## Test plan
- Reset with defaults → LINKUP_STS = 0x0 until cycle 12, then 0x1, then 0x3 at cycle 44, then 0xF at cycle 6044.
- Write X/Y/Z = 12/32/6000, poll LINKUP_STS → 0xF; `tx_online` = 1, `rx_online` = 1.
- WR_RD_ADDR = 0x1000_0000, WR_CFG = 0x00041804 → BUS_STS[4] = 1; DOUT_FIRST = 0x10000003_10000002_10000001_10000000; DOUT_LAST = 0x100001FF_100001FE_100001FD_100001FC.
- RD_CFG = 0x00041804 → BUS_STS[5:0] = 0x3F; DIN_FIRST and DIN_LAST equal the DOUT values; `test_done` = 1.
- WR_CFG start before link is aligned, or during an active burst → ignored; BUS_STS is unchanged.
- With `AXIMM_ERR_INJECT_EN`, RD_CFG = 0x80041804 → BUS_STS[3:0] = 1110; DIN_FIRST = 0x10000003_10000002_10000001_10000001.

Source files
------------

// File: rtl/aximm_aib_top_core_if.sv
// AVMM control port bundle for the AXI-MM over AIB link exerciser.
// master drives requests, slave returns read data.
interface aximm_aib_top_core_if;
    logic        i_wren;
    logic        i_rden;
    logic [31:0] i_wr_addr;
    logic [31:0] i_wrdata;
    logic [31:0] o_master_readdata;
    logic        o_master_readdatavalid;
    logic        o_master_waitrequest;

    modport master (
        output i_wren, i_rden, i_wr_addr, i_wrdata,
        input  o_master_readdata, o_master_readdatavalid,
        input  o_master_waitrequest
    );

    modport slave (
        input  i_wren, i_rden, i_wr_addr, i_wrdata,
        output o_master_readdata, o_master_readdatavalid,
        output o_master_waitrequest
    );
endinterface

// File: rtl/aximm_aib_top_core.sv
// AXI-MM over AIB link exerciser: bring-up model, write/read burst engine.
// Optional AXIMM_ERR_INJECT_EN flips bit 0 of read beat 0 when RD_CFG[31]=1.
module aximm_aib_top_core #(
    parameter int BURST_LEN = 128,
    parameter int LINK_LAT  = 4
) (
    input  logic                ms_wr_clk,
    input  logic                i_w_m_wr_rst,
    aximm_aib_top_core_if.slave avmm,
    output logic                tx_online,
    output logic                rx_online,
    output logic                test_done
);
    localparam int IW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [IW-1:0] LAST = IW'(BURST_LEN - 1);
`ifdef AXIMM_ERR_INJECT_EN
    localparam logic [31:0] RD_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] RD_MASK = 32'h7FFF_FFFF;
`endif

    typedef enum logic [2:0] {IDLE, WR, WR_DRAIN, RD, RD_DRAIN} state_t;
    state_t state, nstate;

    logic [31:0]  cnt, wr_cfg, seed, rd_cfg, dly_x, dly_y, dly_z;
    logic [127:0] dout_f, dout_l, din_f, din_l, beat;
    logic         wr_done, rd_done, cmp_done, cmp_pass, rd_ok, match;
    logic [IW-1:0] idx;
    logic         issue_w, issue_r, last, wr_start, rd_start, aligned;
    logic [33:0]  c34, t_tx, t_rx, t_al;

    logic          wv [LINK_LAT];
    logic          wl [LINK_LAT];
    logic [IW-1:0] wa [LINK_LAT];
    logic [127:0]  wd [LINK_LAT];
    logic          rv [LINK_LAT];
    logic          rl [LINK_LAT];
    logic [IW-1:0] ra [LINK_LAT];
    logic          qv [LINK_LAT];
    logic          ql [LINK_LAT];
    logic [IW-1:0] qa [LINK_LAT];
    logic [127:0]  qd [LINK_LAT];
    logic [127:0]  mem [BURST_LEN];

    logic        rden_q, rise, p1, p2;
    logic [31:0] rd_a, d2, rmux, bus_sts, link_sts;
    logic [127:0] cap;

    function automatic logic [127:0] pat(input logic [31:0] s,
                                         input logic [IW-1:0] k);
        logic [31:0] b;
        b = s + {{(30 - IW){1'b0}}, k, 2'b00};
        return {b + 32'd3, b + 32'd2, b + 32'd1, b};
    endfunction

    assign c34       = {2'b00, cnt};
    assign t_tx      = {2'b00, dly_x};
    assign t_rx      = t_tx + {2'b00, dly_y};
    assign t_al      = t_rx + {2'b00, dly_z};
    assign tx_online = (c34 >= t_tx);
    assign rx_online = (c34 >= t_rx);
    assign aligned   = (c34 >= t_al);
    assign test_done = cmp_done;
    assign avmm.o_master_waitrequest = 1'b0;

    assign bus_sts  = {26'd0, rd_done, wr_done, aligned, aligned,
                       cmp_done, cmp_pass};
    assign link_sts = {28'd0, aligned, aligned, rx_online, tx_online};

    assign wr_start = avmm.i_wren && avmm.i_wr_addr == 32'h5000_1000
                      && avmm.i_wrdata[2] && aligned && state == IDLE;
    assign rd_start = avmm.i_wren && avmm.i_wr_addr == 32'h5000_1010
                      && avmm.i_wrdata[2] && aligned && state == IDLE;
    assign last = (idx == LAST);

`ifdef AXIMM_ERR_INJECT_EN
    assign beat = qd[LINK_LAT-1]
                  ^ {127'd0, rd_cfg[31] && qa[LINK_LAT-1] == '0};
`else
    assign beat = qd[LINK_LAT-1];
`endif
    assign match = (beat == pat(seed, qa[LINK_LAT-1]));

    // engine state register
    always_ff @(posedge ms_wr_clk) begin
        if (i_w_m_wr_rst) state <= IDLE;
        else              state <= nstate;
    end

    // engine next state and beat issue strobes
    always_comb begin
        nstate  = state;
        issue_w = 1'b0;
        issue_r = 1'b0;
        unique case (state)
            IDLE: begin
                if (wr_start)      nstate = WR;
                else if (rd_start) nstate = RD;
            end
            WR: begin
                issue_w = 1'b1;
                if (last) nstate = WR_DRAIN;
            end
            WR_DRAIN: if (wv[LINK_LAT-1] && wl[LINK_LAT-1]) nstate = IDLE;
            RD: begin
                issue_r = 1'b1;
                if (last) nstate = RD_DRAIN;
            end
            RD_DRAIN: if (qv[LINK_LAT-1] && ql[LINK_LAT-1]) nstate = IDLE;
            default:  nstate = IDLE;
        endcase
    end

    // bring-up counter and AVMM-writable configuration
    always_ff @(posedge ms_wr_clk) begin
        if (i_w_m_wr_rst) begin
            cnt <= '0; wr_cfg <= '0; seed <= '0; rd_cfg <= '0;
            dly_x <= 32'd12; dly_y <= 32'd32; dly_z <= 32'd6000;
        end else begin
            if (cnt != '1) cnt <= cnt + 32'd1;
            if (avmm.i_wren) begin
                case (avmm.i_wr_addr)
                    32'h5000_1000: wr_cfg <= avmm.i_wrdata;
                    32'h5000_1004: seed   <= avmm.i_wrdata;
                    32'h5000_1010: rd_cfg <= avmm.i_wrdata & RD_MASK;
                    32'h5000_2000: dly_x  <= avmm.i_wrdata;
                    32'h5000_2004: dly_y  <= avmm.i_wrdata;
                    32'h5000_2008: dly_z  <= avmm.i_wrdata;
                    default: ;
                endcase
            end
        end
    end

    // beat counter, link pipe valids, captures and status
    always_ff @(posedge ms_wr_clk) begin
        if (i_w_m_wr_rst) begin
            idx <= '0; wr_done <= 1'b0; rd_done <= 1'b0;
            cmp_done <= 1'b0; cmp_pass <= 1'b0; rd_ok <= 1'b0;
            dout_f <= '0; dout_l <= '0; din_f <= '0; din_l <= '0;
            for (int i = 0; i < LINK_LAT; i++) begin
                wv[i] <= 1'b0; wl[i] <= 1'b0; rv[i] <= 1'b0;
                rl[i] <= 1'b0; qv[i] <= 1'b0; ql[i] <= 1'b0;
            end
        end else begin
            if (wr_start || rd_start)     idx <= '0;
            else if (issue_w || issue_r) idx <= idx + 1'b1;
            wv[0] <= issue_w; wl[0] <= issue_w && last;
            rv[0] <= issue_r; rl[0] <= issue_r && last;
            qv[0] <= rv[LINK_LAT-1]; ql[0] <= rl[LINK_LAT-1];
            for (int i = 1; i < LINK_LAT; i++) begin
                wv[i] <= wv[i-1]; wl[i] <= wl[i-1];
                rv[i] <= rv[i-1]; rl[i] <= rl[i-1];
                qv[i] <= qv[i-1]; ql[i] <= ql[i-1];
            end
            if (wr_start) begin
                wr_done <= 1'b0; rd_done <= 1'b0;
                cmp_done <= 1'b0; cmp_pass <= 1'b0;
            end
            if (rd_start) begin
                rd_done <= 1'b0; cmp_done <= 1'b0;
                cmp_pass <= 1'b0; rd_ok <= 1'b1;
            end
            if (issue_w && idx == '0) dout_f <= pat(seed, idx);
            if (issue_w && last)      dout_l <= pat(seed, idx);
            if (wv[LINK_LAT-1] && wl[LINK_LAT-1]) wr_done <= 1'b1;
            if (qv[LINK_LAT-1]) begin
                rd_ok <= rd_ok & match;
                if (qa[LINK_LAT-1] == '0) din_f <= beat;
                if (ql[LINK_LAT-1]) begin
                    din_l    <= beat;
                    rd_done  <= 1'b1;
                    cmp_done <= 1'b1;
                    cmp_pass <= rd_ok & match;
                end
            end
        end
    end

    // link pipe payloads and far-side memory (not reset)
    always_ff @(posedge ms_wr_clk) begin
        wa[0] <= idx;
        wd[0] <= pat(seed, idx);
        ra[0] <= idx;
        qa[0] <= ra[LINK_LAT-1];
        qd[0] <= mem[ra[LINK_LAT-1]];
        for (int i = 1; i < LINK_LAT; i++) begin
            wa[i] <= wa[i-1]; wd[i] <= wd[i-1];
            ra[i] <= ra[i-1]; qa[i] <= qa[i-1]; qd[i] <= qd[i-1];
        end
        if (wv[LINK_LAT-1]) mem[wa[LINK_LAT-1]] <= wd[LINK_LAT-1];
    end

    // AVMM read address decode
    always_comb begin
        rmux = '0;
        cap  = '0;
        unique case (rd_a[5:4])
            2'd0: cap = dout_f;
            2'd1: cap = dout_l;
            2'd2: cap = din_f;
            default: cap = din_l;
        endcase
        case (rd_a)
            32'h5000_1000: rmux = wr_cfg;
            32'h5000_1004: rmux = seed;
            32'h5000_1008: rmux = bus_sts;
            32'h5000_100C: rmux = link_sts;
            32'h5000_1010: rmux = rd_cfg;
            32'h5000_2000: rmux = dly_x;
            32'h5000_2004: rmux = dly_y;
            32'h5000_2008: rmux = dly_z;
            default:
                if ((rd_a & 32'hFFFF_FFC3) == 32'h5000_4000)
                    rmux = cap[{rd_a[3:2], 5'd0} +: 32];
        endcase
    end

    // AVMM read: edge-triggered request, data valid two cycles later, held
    always_ff @(posedge ms_wr_clk) begin
        if (i_w_m_wr_rst) begin
            rden_q <= 1'b0; p1 <= 1'b0; p2 <= 1'b0;
            rd_a <= '0; d2 <= '0;
            avmm.o_master_readdata      <= '0;
            avmm.o_master_readdatavalid <= 1'b0;
        end else begin
            rden_q <= avmm.i_rden;
            p1 <= rise;
            p2 <= p1;
            if (rise) rd_a <= avmm.i_wr_addr;
            if (p1)   d2 <= rmux;
            if (p2) begin
                avmm.o_master_readdata      <= d2;
                avmm.o_master_readdatavalid <= 1'b1;
            end
            if (rise) avmm.o_master_readdatavalid <= 1'b0;
        end
    end
    assign rise = avmm.i_rden && !rden_q;
endmodule

// File: tb/tb_aximm_aib_top_core.sv
// Self-checking bench for aximm_aib_top_core: bring-up timing, bursts,
// ignored starts, random seeds, error injection and mid-burst reset.
module tb_aximm_aib_top_core;
    localparam logic [31:0] A_WCFG = 32'h5000_1000;
    localparam logic [31:0] A_SEED = 32'h5000_1004;
    localparam logic [31:0] A_BUS  = 32'h5000_1008;
    localparam logic [31:0] A_LINK = 32'h5000_100C;
    localparam logic [31:0] A_RCFG = 32'h5000_1010;
    localparam logic [31:0] A_DX   = 32'h5000_2000;
    localparam logic [31:0] A_DY   = 32'h5000_2004;
    localparam logic [31:0] A_DZ   = 32'h5000_2008;
    localparam logic [31:0] A_DOF  = 32'h5000_4000;
    localparam logic [31:0] A_DOL  = 32'h5000_4010;
    localparam logic [31:0] A_DIF  = 32'h5000_4020;
    localparam logic [31:0] A_DIL  = 32'h5000_4030;
    localparam int NB = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx, rx, td;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic last_v0;
    int   last_lat;

    always #5 clk = ~clk;

    aximm_aib_top_core_if bus ();

    aximm_aib_top_core #(.BURST_LEN(NB), .LINK_LAT(4)) dut (
        .ms_wr_clk    (clk),
        .i_w_m_wr_rst (rst),
        .avmm         (bus.slave),
        .tx_online    (tx),
        .rx_online    (rx),
        .test_done    (td)
    );

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [31:0] pw(logic [31:0] s, int k, int j);
        return s + 32'(4 * k + j);
    endfunction

    function automatic logic [127:0] pbeat(logic [31:0] s, int k);
        return {pw(s, k, 3), pw(s, k, 2), pw(s, k, 1), pw(s, k, 0)};
    endfunction

    task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", n, got, exp);
        end
    endtask

    task automatic wr(logic [31:0] a, logic [31:0] d);
        @(negedge clk);
        bus.i_wren = 1'b1; bus.i_wr_addr = a; bus.i_wrdata = d;
        @(negedge clk);
        bus.i_wren = 1'b0;
    endtask

    task automatic rd(logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.i_rden = 1'b1; bus.i_wr_addr = a;
        @(negedge clk);
        bus.i_rden = 1'b0;
        last_v0 = bus.o_master_readdatavalid;
        last_lat = 0;
        for (int n = 1; n <= 8 && last_lat == 0; n++) begin
            @(negedge clk);
            if (bus.o_master_readdatavalid) last_lat = n;
        end
        if (last_lat == 0) begin
            total++; bad++;
            $display("FAIL rd_timeout addr=%h got=no-valid exp=valid", a);
        end
        d = bus.o_master_readdata;
    endtask

    task automatic rdchk(string n, logic [31:0] a, logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        chk(n, d, exp);
    endtask

    task automatic settle(int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s, s2, d;
        logic [127:0] b;
        int k;
        logic mism;

        s = 32'h1000_0000;
        tbl.push_back('{"bus_sts",   A_BUS,  32'h3F});
        tbl.push_back('{"link_sts",  A_LINK, 32'hF});
        tbl.push_back('{"wr_cfg",    A_WCFG, 32'h0004_1804});
        tbl.push_back('{"seed",      A_SEED, s});
        tbl.push_back('{"dly_x",     A_DX,   32'd12});
        tbl.push_back('{"dly_y",     A_DY,   32'd32});
        tbl.push_back('{"dly_z",     A_DZ,   32'd6000});
        tbl.push_back('{"unmapped0", 32'h5000_1014, 32'h0});
        tbl.push_back('{"unmapped1", 32'h5000_4040, 32'h0});
        for (int j = 0; j < 4; j++) begin
            b = pbeat(s, 0);
            tbl.push_back('{$sformatf("dout_first%0d", j),
                            A_DOF + 32'(4 * j), b[32*j +: 32]});
            tbl.push_back('{$sformatf("din_first%0d", j),
                            A_DIF + 32'(4 * j), b[32*j +: 32]});
            b = pbeat(s, NB - 1);
            tbl.push_back('{$sformatf("dout_last%0d", j),
                            A_DOL + 32'(4 * j), b[32*j +: 32]});
            tbl.push_back('{$sformatf("din_last%0d", j),
                            A_DIL + 32'(4 * j), b[32*j +: 32]});
        end

        bus.i_wren = 1'b0; bus.i_rden = 1'b0;
        bus.i_wr_addr = '0; bus.i_wrdata = '0;
        settle(3);
        rst = 1'b0;

        chk("rst_tx", 32'(tx), 0);
        chk("rst_rx", 32'(rx), 0);
        chk("rst_done", 32'(td), 0);
        chk("rst_rdata", bus.o_master_readdata, 0);
        chk("rst_valid", 32'(bus.o_master_readdatavalid), 0);
        chk("rst_wait", 32'(bus.o_master_waitrequest), 0);

        while (cyc < 11) @(negedge clk);
        chk("tx_c11", 32'(tx), 0);
        @(negedge clk);
        chk("tx_c12", 32'(tx), 1);
        chk("rx_c12", 32'(rx), 0);
        while (cyc < 43) @(negedge clk);
        chk("rx_c43", 32'(rx), 0);
        @(negedge clk);
        chk("rx_c44", 32'(rx), 1);

        wr(A_SEED, s);
        wr(A_WCFG, 32'h4);
        settle(300);
        rdchk("early_start_bus", A_BUS, 32'h0);
        rdchk("link_pre_align", A_LINK, 32'h3);
        chk("rd_valid_cleared", 32'(last_v0), 0);
        chk("rd_latency", 32'(last_lat), 2);

        while (cyc < 6000) @(negedge clk);
        rdchk("link_6000", A_LINK, 32'h3);
        while (cyc < 6050) @(negedge clk);
        rdchk("link_aligned", A_LINK, 32'hF);
        chk("tx_up", 32'(tx), 1);
        chk("rx_up", 32'(rx), 1);

        wr(A_DX, 32'd12); wr(A_DY, 32'd32); wr(A_DZ, 32'd6000);

        wr(A_SEED, 32'h2000_0000);
        wr(A_WCFG, 32'h4);
        settle(10);
        wr(A_SEED, 32'h3000_0000);
        wr(A_WCFG, 32'h4);
        wr(A_RCFG, 32'h4);
        settle(300);
        rdchk("busy_start_bus", A_BUS, 32'h1C);
        rdchk("busy_start_dof", A_DOF, 32'h2000_0000);

        wr(A_SEED, s);
        wr(A_WCFG, 32'h0004_1804);
        settle(300);
        rdchk("wr_done_bus", A_BUS, 32'h1C);
        wr(A_RCFG, 32'h0004_1804);
        settle(300);
        foreach (tbl[i]) rdchk(tbl[i].name, tbl[i].addr, tbl[i].exp);
        chk("test_done", 32'(td), 1);

`ifdef AXIMM_ERR_INJECT_EN
        wr(A_RCFG, 32'h8004_1804);
        settle(300);
        rdchk("inj_bus", A_BUS, 32'h3E);
        rdchk("inj_din_first0", A_DIF, 32'h1000_0001);
        rdchk("inj_din_first1", A_DIF + 32'd4, 32'h1000_0002);
        wr(A_RCFG, 32'h0);
`endif

        for (int it = 0; it < 4; it++) begin
            s = $urandom;
            mism = (it == 2);
            wr(A_SEED, s);
            wr(A_WCFG, 32'h4);
            settle(300);
            if (mism) begin
                s2 = s ^ 32'h0000_0100;
                wr(A_SEED, s2);
            end
            wr(A_RCFG, 32'h4);
            settle(300);
            rdchk($sformatf("rnd%0d_bus", it), A_BUS,
                  mism ? 32'h3E : 32'h3F);
            k = $urandom_range(0, 3);
            b = pbeat(s, 0);
            rdchk($sformatf("rnd%0d_dof", it), A_DOF + 32'(4 * k),
                  b[32*k +: 32]);
            rdchk($sformatf("rnd%0d_dif", it), A_DIF + 32'(4 * k),
                  b[32*k +: 32]);
            b = pbeat(s, NB - 1);
            rdchk($sformatf("rnd%0d_dil", it), A_DIL + 32'(4 * k),
                  b[32*k +: 32]);
        end

        wr(A_DY, 32'd7);
        wr(A_RCFG, 32'h4);
        settle(30);
        @(negedge clk);
        rst = 1'b1;
        settle(2);
        rst = 1'b0;
        chk("mid_rst_tx", 32'(tx), 0);
        chk("mid_rst_done", 32'(td), 0);
        rdchk("mid_rst_bus", A_BUS, 32'h0);
        rdchk("mid_rst_dif", A_DIF, 32'h0);
        rdchk("mid_rst_dy", A_DY, 32'd32);
        rdchk("mid_rst_seed", A_SEED, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
